// File: rtl/rob_writeback_commit_pkg.sv
// Shared widths and the reorder-buffer entry record for rob_writeback_commit.
// WORD_SIZE is 32 and INSTR_TYPE_SZ is 4.
package rob_writeback_commit_pkg;

  localparam int WORD_SIZE = 32;
  localparam int INSTR_TYPE_SZ = 4;

  localparam int ROB_ID_SZ = 7;
  localparam int RD_SZ     = 5;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic [WORD_SIZE-1:0]     pc;
    logic [INSTR_TYPE_SZ-1:0] itype;
    logic [RD_SZ-1:0]         rd;
    logic                     rd_we;
    logic [WORD_SIZE-1:0]     result;
  } rob_entry_t;

  // x0 is hardwired to zero, so an rd of 0 never produces a register-file write.
  function automatic logic rd_writes(input logic rd_we, input logic [RD_SZ-1:0] rd);
    return rd_we && (rd != '0);
  endfunction

endpackage

// File: rtl/rob_writeback_commit_if.sv
// Decode-alloc, WB-result and commit bundle between the pipeline (master) and the ROB (slave).
// The fwd_* lookup signals exist only when ROB_FORWARD_EN is defined.
interface rob_writeback_commit_if;
  import rob_writeback_commit_pkg::*;

  logic                     flush;

  logic                     alloc_valid;
  logic [WORD_SIZE-1:0]     alloc_pc;
  logic [INSTR_TYPE_SZ-1:0] alloc_type;
  logic [RD_SZ-1:0]         alloc_rd;
  logic                     alloc_rd_we;
  logic                     alloc_ready;
  logic [ROB_ID_SZ-1:0]     alloc_rob_id;

  logic                     wb_valid;
  logic [ROB_ID_SZ-1:0]     wb_rob_id;
  logic [WORD_SIZE-1:0]     wb_result;

  logic                     commit_valid;
  logic [ROB_ID_SZ-1:0]     commit_rob_id;
  logic [WORD_SIZE-1:0]     commit_pc;
  logic [INSTR_TYPE_SZ-1:0] commit_type;
  logic [RD_SZ-1:0]         commit_rd;
  logic                     commit_we;
  logic [WORD_SIZE-1:0]     commit_result;

  logic                     empty;

`ifdef ROB_FORWARD_EN
  logic [ROB_ID_SZ-1:0]     fwd_rob_id;
  logic                     fwd_ready;
  logic [WORD_SIZE-1:0]     fwd_value;
`endif

  modport master (
    output flush, alloc_valid, alloc_pc, alloc_type, alloc_rd, alloc_rd_we,
    output wb_valid, wb_rob_id, wb_result,
    input  alloc_ready, alloc_rob_id,
    input  commit_valid, commit_rob_id, commit_pc, commit_type, commit_rd, commit_we, commit_result,
    input  empty
`ifdef ROB_FORWARD_EN
    , output fwd_rob_id
    , input  fwd_ready, fwd_value
`endif
  );

  modport slave (
    input  flush, alloc_valid, alloc_pc, alloc_type, alloc_rd, alloc_rd_we,
    input  wb_valid, wb_rob_id, wb_result,
    output alloc_ready, alloc_rob_id,
    output commit_valid, commit_rob_id, commit_pc, commit_type, commit_rd, commit_we, commit_result,
    output empty
`ifdef ROB_FORWARD_EN
    , input  fwd_rob_id
    , output fwd_ready, fwd_value
`endif
  );

endinterface

// File: rtl/rob_ptr.sv
// Circular ROB pointer: IDX_W index bits plus a wrap bit; clear beats increment; 1-cycle update.
// Always accepts inc_i; the owner gates it with its own full/empty logic.
module rob_ptr #(
  parameter int IDX_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_i,
  input  logic           inc_i,
  output logic [IDX_W:0] ptr_o
);

  logic [IDX_W:0] ptr_q;
  logic [IDX_W:0] ptr_d;

  // Entry count is a power of two, so natural overflow of the index bits is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_writeback_commit.sv
// In-order retire ROB: WB in cycle N to the head entry -> commit_valid in N+2; one retirement per cycle.
// alloc_ready drops when full (registered state only); flush wins over alloc/WB/commit; ROB_FORWARD_EN adds a result lookup.
module rob_writeback_commit
  import rob_writeback_commit_pkg::*;
#(
  parameter int ROB_ENTRIES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  rob_writeback_commit_if.slave bus
);

  localparam int IDX_W = $clog2(ROB_ENTRIES);

  logic [IDX_W:0]   head_ptr;
  logic [IDX_W:0]   tail_ptr;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic [IDX_W-1:0] wb_idx;

  rob_entry_t entries_q [ROB_ENTRIES];
  rob_entry_t entries_d [ROB_ENTRIES];
  rob_entry_t head_ent;

  logic full;
  logic empty_w;
  logic alloc_fire;
  logic wb_hit;
  logic commit_fire;

  logic                     commit_valid_q;
  logic [ROB_ID_SZ-1:0]     commit_rob_id_q;
  logic [WORD_SIZE-1:0]     commit_pc_q;
  logic [INSTR_TYPE_SZ-1:0] commit_type_q;
  logic [RD_SZ-1:0]         commit_rd_q;
  logic                     commit_we_q;
  logic [WORD_SIZE-1:0]     commit_result_q;

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];
  assign wb_idx   = bus.wb_rob_id[IDX_W-1:0];
  assign head_ent = entries_q[head_idx];

  assign empty_w = (head_ptr == tail_ptr);
  assign full    = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);

  assign alloc_fire  = bus.alloc_valid && !full && !bus.flush;
  assign wb_hit      = bus.wb_valid && entries_q[wb_idx].busy && !bus.flush;
  assign commit_fire = head_ent.busy && head_ent.done && !bus.flush;

  rob_ptr #(.IDX_W(IDX_W)) u_head_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.flush),
    .inc_i   (commit_fire),
    .ptr_o   (head_ptr)
  );

  rob_ptr #(.IDX_W(IDX_W)) u_tail_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.flush),
    .inc_i   (alloc_fire),
    .ptr_o   (tail_ptr)
  );

  // Alloc only targets a free slot and WB only a busy one, so the three updates never collide.
  always_comb begin
    entries_d = entries_q;
    if (wb_hit) begin
      entries_d[wb_idx].done   = 1'b1;
      entries_d[wb_idx].result = bus.wb_result;
    end
    if (commit_fire) begin
      entries_d[head_idx].busy = 1'b0;
      entries_d[head_idx].done = 1'b0;
    end
    if (alloc_fire) begin
      entries_d[tail_idx].busy   = 1'b1;
      entries_d[tail_idx].done   = 1'b0;
      entries_d[tail_idx].pc     = bus.alloc_pc;
      entries_d[tail_idx].itype  = bus.alloc_type;
      entries_d[tail_idx].rd     = bus.alloc_rd;
      entries_d[tail_idx].rd_we  = bus.alloc_rd_we;
      entries_d[tail_idx].result = '0;
    end
    if (bus.flush) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        entries_d[i].busy = 1'b0;
        entries_d[i].done = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  // Commit fields hold their last value while commit_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_valid_q  <= 1'b0;
      commit_rob_id_q <= '0;
      commit_pc_q     <= '0;
      commit_type_q   <= '0;
      commit_rd_q     <= '0;
      commit_we_q     <= 1'b0;
      commit_result_q <= '0;
    end else begin
      commit_valid_q <= commit_fire;
      commit_we_q    <= commit_fire && rd_writes(head_ent.rd_we, head_ent.rd);
      if (commit_fire) begin
        commit_rob_id_q <= ROB_ID_SZ'(head_idx);
        commit_pc_q     <= head_ent.pc;
        commit_type_q   <= head_ent.itype;
        commit_rd_q     <= head_ent.rd;
        commit_result_q <= head_ent.result;
      end
    end
  end

  assign bus.alloc_ready   = !full;
  assign bus.alloc_rob_id  = ROB_ID_SZ'(tail_idx);
  assign bus.empty         = empty_w;
  assign bus.commit_valid  = commit_valid_q;
  assign bus.commit_rob_id = commit_rob_id_q;
  assign bus.commit_pc     = commit_pc_q;
  assign bus.commit_type   = commit_type_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_we     = commit_we_q;
  assign bus.commit_result = commit_result_q;

`ifdef ROB_FORWARD_EN
  logic [IDX_W-1:0] fwd_idx;
  assign fwd_idx       = bus.fwd_rob_id[IDX_W-1:0];
  assign bus.fwd_ready = entries_q[fwd_idx].busy && entries_q[fwd_idx].done;
  assign bus.fwd_value = bus.fwd_ready ? entries_q[fwd_idx].result : '0;
`endif

  // Only the low IDX_W bits of an id select an entry.
  if (IDX_W < ROB_ID_SZ) begin : g_id_hi
    logic unused_id_hi;
`ifdef ROB_FORWARD_EN
    assign unused_id_hi = ^{bus.wb_rob_id[ROB_ID_SZ-1:IDX_W], bus.fwd_rob_id[ROB_ID_SZ-1:IDX_W]};
`else
    assign unused_id_hi = ^bus.wb_rob_id[ROB_ID_SZ-1:IDX_W];
`endif
  end

endmodule

// File: tb/tb_rob_writeback_commit.sv
// Directed bench for rob_writeback_commit: in-order retire, full, wrap, flush, rd=0 and async reset.
// Forward-lookup steps are built only when ROB_FORWARD_EN is defined.
module tb_rob_writeback_commit;
  import rob_writeback_commit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rob_writeback_commit_if bus();

  rob_writeback_commit #(.ROB_ENTRIES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alloc(input logic v, input logic [31:0] pc, input logic [3:0] ty,
                           input logic [4:0] rd, input logic we);
    bus.alloc_valid = v;
    bus.alloc_pc    = pc;
    bus.alloc_type  = ty;
    bus.alloc_rd    = rd;
    bus.alloc_rd_we = we;
  endtask

  task automatic set_wb(input logic v, input logic [6:0] id, input logic [31:0] res);
    bus.wb_valid  = v;
    bus.wb_rob_id = id;
    bus.wb_result = res;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0;
    set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
    set_wb(1'b0, 7'd0, 32'h0);
`ifdef ROB_FORWARD_EN
    bus.fwd_rob_id = 7'd0;
`endif

    // Reset state
    tick();
    tick();
    check("rst_empty", bus.empty, 1);
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_alloc_id", bus.alloc_rob_id, 0);
    check("rst_commit_valid", bus.commit_valid, 0);
    check("rst_commit_pc", bus.commit_pc, 0);
    check("rst_commit_result", bus.commit_result, 0);
    check("rst_commit_we", bus.commit_we, 0);
    reset = 1'b0;

    // 1: three allocs, WB out of order, retire in order
    set_alloc(1'b1, 32'h100, 4'h1, 5'd5, 1'b1); check("t1_id0", bus.alloc_rob_id, 0); tick();
    set_alloc(1'b1, 32'h104, 4'h2, 5'd6, 1'b0); check("t1_id1", bus.alloc_rob_id, 1); tick();
    set_alloc(1'b1, 32'h108, 4'h3, 5'd7, 1'b1); check("t1_id2", bus.alloc_rob_id, 2); tick();
    set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
    check("t1_not_empty", bus.empty, 0);
    set_wb(1'b1, 7'd2, 32'hA2); tick();
    check("t1_no_early_commit", bus.commit_valid, 0);
    set_wb(1'b1, 7'd1, 32'hA1); tick();
    set_wb(1'b1, 7'd0, 32'hA0); tick();
    set_wb(1'b0, 7'd0, 32'h0);
    check("t1_lat_n1", bus.commit_valid, 0);
    tick();
    check("t1_c0_valid", bus.commit_valid, 1);
    check("t1_c0_id", bus.commit_rob_id, 0);
    check("t1_c0_pc", bus.commit_pc, 32'h100);
    check("t1_c0_res", bus.commit_result, 32'hA0);
    check("t1_c0_rd", bus.commit_rd, 5);
    check("t1_c0_we", bus.commit_we, 1);
    check("t1_c0_type", bus.commit_type, 1);
    tick();
    check("t1_c1_valid", bus.commit_valid, 1);
    check("t1_c1_id", bus.commit_rob_id, 1);
    check("t1_c1_pc", bus.commit_pc, 32'h104);
    check("t1_c1_we", bus.commit_we, 0);
    tick();
    check("t1_c2_id", bus.commit_rob_id, 2);
    check("t1_c2_res", bus.commit_result, 32'hA2);
    check("t1_c2_we", bus.commit_we, 1);
    tick();
    check("t1_idle_valid", bus.commit_valid, 0);
    check("t1_idle_hold_pc", bus.commit_pc, 32'h108);
    check("t1_idle_empty", bus.empty, 1);

    // 2: fill all 8, ninth ignored, one retire frees a slot
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(1'b1, 32'h200 + 32'(i * 4), 4'h0, 5'd1, 1'b1);
      check("t2_ready_before", bus.alloc_ready, 1);
      tick();
    end
    check("t2_full_ready", bus.alloc_ready, 0);
    set_alloc(1'b1, 32'h999, 4'h0, 5'd1, 1'b1);
    tick();
    set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
    check("t2_ninth_ready", bus.alloc_ready, 0);
    check("t2_ninth_tail", bus.alloc_rob_id, 0);
    set_wb(1'b1, 7'd0, 32'h11); tick();
    set_wb(1'b0, 7'd0, 32'h0);
    check("t2_still_full", bus.alloc_ready, 0);
    tick();
    check("t2_commit_valid", bus.commit_valid, 1);
    check("t2_commit_pc", bus.commit_pc, 32'h200);
    check("t2_ready_again", bus.alloc_ready, 1);

    // 3: wrap through 20 alloc/WB/commit rounds
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_alloc(1'b1, 32'h1000 + 32'(i * 4), 4'h0, 5'd2, 1'b1);
      check("t3_alloc_id", bus.alloc_rob_id, 32'(i % 8));
      tick();
      set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
      set_wb(1'b1, 7'(i % 8), 32'(i * 3 + 1));
      tick();
      set_wb(1'b0, 7'd0, 32'h0);
      tick();
      check("t3_commit_valid", bus.commit_valid, 1);
      check("t3_commit_id", bus.commit_rob_id, 32'(i % 8));
      check("t3_commit_pc", bus.commit_pc, 32'h1000 + 32'(i * 4));
    end

    // 4: flush squashes everything; stale WB ignored
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(1'b1, 32'h300 + 32'(i * 4), 4'h0, 5'd3, 1'b1);
      tick();
    end
    set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
    set_wb(1'b1, 7'd1, 32'h77); tick();
    set_wb(1'b0, 7'd0, 32'h0);
    bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    check("t4_flush_empty", bus.empty, 1);
    check("t4_flush_id", bus.alloc_rob_id, 0);
    check("t4_flush_commit", bus.commit_valid, 0);
    set_wb(1'b1, 7'd1, 32'h78); tick();
    set_wb(1'b0, 7'd0, 32'h0);
    tick();
    check("t4_stale_wb_commit", bus.commit_valid, 0);
    check("t4_stale_wb_empty", bus.empty, 1);
    set_alloc(1'b1, 32'h400, 4'h0, 5'd4, 1'b1);
    check("t4_new_id", bus.alloc_rob_id, 0);
    tick();
    set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
    tick();
    tick();
    check("t4_needs_wb", bus.commit_valid, 0);
    set_wb(1'b1, 7'd0, 32'h44); tick();
    set_wb(1'b0, 7'd0, 32'h0);
    tick();
    check("t4_commit_valid", bus.commit_valid, 1);
    check("t4_commit_pc", bus.commit_pc, 32'h400);
    check("t4_commit_res", bus.commit_result, 32'h44);

    // 5: rd = x0 retires but does not write
    do_reset();
    set_alloc(1'b1, 32'h500, 4'h5, 5'd0, 1'b1); tick();
    set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
    set_wb(1'b1, 7'd0, 32'hDEADBEEF); tick();
    set_wb(1'b0, 7'd0, 32'h0);
    tick();
    check("t5_valid", bus.commit_valid, 1);
    check("t5_result", bus.commit_result, 32'hDEADBEEF);
    check("t5_we", bus.commit_we, 0);

    // Asynchronous reset mid-operation discards the in-flight WB
    do_reset();
    set_alloc(1'b1, 32'h600, 4'h0, 5'd1, 1'b1); tick();
    set_alloc(1'b1, 32'h604, 4'h0, 5'd1, 1'b1); tick();
    set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
    set_wb(1'b1, 7'd0, 32'h66); tick();
    set_wb(1'b0, 7'd0, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("ar_empty", bus.empty, 1);
    check("ar_ready", bus.alloc_ready, 1);
    check("ar_id", bus.alloc_rob_id, 0);
    check("ar_commit", bus.commit_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("ar_no_commit", bus.commit_valid, 0);
    check("ar_commit_pc", bus.commit_pc, 0);

`ifdef ROB_FORWARD_EN
    // 6: forward lookup, WB visible only the cycle after
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(1'b1, 32'h700 + 32'(i * 4), 4'h0, 5'd1, 1'b1);
      tick();
    end
    set_alloc(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
    bus.fwd_rob_id = 7'd3;
    set_wb(1'b1, 7'd3, 32'h55);
    #1;
    check("t6_fwd_same_cycle", bus.fwd_ready, 0);
    check("t6_fwd_val_zero", bus.fwd_value, 0);
    tick();
    set_wb(1'b0, 7'd0, 32'h0);
    check("t6_fwd_ready", bus.fwd_ready, 1);
    check("t6_fwd_value", bus.fwd_value, 32'h55);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_fwd_ready", bus.fwd_ready, 0);
    check("t6_rst_fwd_value", bus.fwd_value, 0);
    tick();
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
